ips2l_pcie_dma_tx_cpld_gen: RTL and testbench

//  Completer-side transmitter: turns MRd requests from the DMA RX path into CplD TLPs on the PCIe AXIS slave (TX) port.

---
 rtl/ips2l_pcie_dma_tx_cpld_gen_pkg.sv | 54 +++++
 rtl/ips2l_pcie_dma_tx_dw_align.sv | 42 ++++
 rtl/ips2l_pcie_dma_tx_cpld_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_ips2l_pcie_dma_tx_cpld_gen.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ips2l_pcie_dma_tx_cpld_gen_pkg.sv
// Shared definitions for the CplD generator: FSM encodings, CplD header
// constants and field offsets, MPS decode and last-beat keep helpers.
package ips2l_pcie_dma_tx_cpld_gen_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SPLIT = 3'd1;
  localparam logic [2:0] ST_PREF  = 3'd2;
  localparam logic [2:0] ST_HDR   = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;

  // CplD format/type
  localparam logic [2:0] CPLD_FMT  = 3'b010;
  localparam logic [4:0] CPLD_TYPE = 5'b01010;

  // Header DW0 field offsets
  localparam int DW0_FMT_LSB   = 29;
  localparam int DW0_TYPE_LSB  = 24;
  localparam int DW0_TC_LSB    = 20;
  localparam int DW0_ATTR2_BIT = 18;
  localparam int DW0_ATTR_LSB  = 12;

  // MPS code to DW count; codes above 5 behave as 4096 bytes
  function automatic logic [10:0] mps_dw(input logic [2:0] code);
    logic [2:0] c;
    c = (code > 3'd5) ? 3'd5 : code;
    return 11'd32 << c;
  endfunction

  // Keep mask for the last beat given the DWs still left in the TLP (1..4)
  function automatic logic [3:0] keep_mask(input logic [10:0] left);
    case (left[2:0])
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  // CplD header DW0: TD=0, EP=0, reserved/LN/TH/AT all zero
  function automatic logic [31:0] cpld_dw0(input logic [2:0] tc, input logic [2:0] attr,
                                           input logic [9:0] len);
    logic [31:0] dw;
    dw = '0;
    dw[DW0_FMT_LSB +: 3]      = CPLD_FMT;
    dw[DW0_TYPE_LSB +: 5]     = CPLD_TYPE;
    dw[DW0_TC_LSB +: 3]       = tc;
    dw[DW0_ATTR2_BIT]         = attr[2];
    dw[DW0_ATTR_LSB +: 2]     = attr[1:0];
    dw[9:0]                   = len;
    return dw;
  endfunction

endpackage

// File: rtl/ips2l_pcie_dma_tx_dw_align.sv
// DW realigner: combines the current RAM word with the previous one and
// emits a beat in which payload DW k lands in stream slot 3+k, given the
// starting DW offset inside the first RAM word.
module ips2l_pcie_dma_tx_dw_align (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] i_word,
  input  logic [1:0]   i_offset,
  input  logic         i_hold,
  output logic [127:0] o_beat
);

  // Only DW1..DW3 of the previous word can ever reach the output
  logic [95:0]  hold_q, hold_d;
  logic [223:0] cat;

  assign cat = {i_word, hold_q};

  // Capture the word being consumed whenever the beat advances
  always_comb begin
    hold_d = hold_q;
    if (!i_hold) hold_d = i_word[127:32];
  end

  // Holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end

  // Select the 4-DW window starting at previous-word slot offset+1
  always_comb begin
    o_beat = cat[127:0];
    case (i_offset)
      2'd0:    o_beat = cat[127:0];
      2'd1:    o_beat = cat[159:32];
      2'd2:    o_beat = cat[191:64];
      default: o_beat = cat[223:96];
    endcase
  end

endmodule

// File: rtl/ips2l_pcie_dma_tx_cpld_gen.sv
// Completer CplD generator: converts MRd requests into 3DW CplD TLPs on the
// AXIS TX port, reading payload from BAR0 RAM and splitting on MPS boundaries.
// Handshake: a beat transfers when tvld && trdy; once tvld rises, tdata/tkeep/
// tlast hold until that transfer, and requests transfer when vld && rdy.
// Optional feature macro: CPLD_STAT_EN builds the completion/DW counters.
module ips2l_pcie_dma_tx_cpld_gen
  import ips2l_pcie_dma_tx_cpld_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            i_cfg_max_payload_size,
  input  logic [15:0]           i_cfg_completer_id,
  input  logic [2:0]            i_mrd_tc,
  input  logic [2:0]            i_mrd_attr,
  input  logic [9:0]            i_mrd_length,
  input  logic [15:0]           i_mrd_id,
  input  logic [7:0]            i_mrd_tag,
  input  logic [63:0]           i_mrd_addr,
  input  logic                  i_cpld_req_vld,
  output logic                  o_cpld_req_rdy,
  output logic                  o_cpld_tx_rdy,
  output logic                  o_bar0_rd_clk_en,
  output logic [ADDR_WIDTH-1:0] o_bar0_rd_addr,
  input  logic [127:0]          i_bar0_rd_data,
  output logic                  o_axis_slave_tvld,
  input  logic                  i_axis_slave_trdy,
  output logic [127:0]          o_axis_slave_tdata,
  output logic [3:0]            o_axis_slave_tkeep,
  output logic                  o_axis_slave_tlast,
  output logic [63:0]           o_cpld_stat,
  output logic [2:0]            o_dbg_state
);

  localparam int DWA_W = ADDR_WIDTH + 2;

  logic [2:0]            state_q, state_d;
  logic [2:0]            tc_q, tc_d, attr_q, attr_d;
  logic [15:0]           rid_q, rid_d;
  logic [7:0]            tag_q, tag_d;
  logic [10:0]           rem_q, rem_d;       // DWs still owed to the request
  logic [DWA_W-1:0]      dwa_q, dwa_d;       // BAR0 DW address of next payload
  logic [10:0]           chunk_q, chunk_d;   // payload DWs of current TLP
  logic [11:0]           bcnt_q, bcnt_d;
  logic [6:0]            laddr_q, laddr_d;
  logic [10:0]           left_q, left_d;     // TLP DWs (header included) not yet sent
  logic [ADDR_WIDTH-1:0] word_q, word_d;     // next RAM word to read

  logic                  is_beat, beat_hs, beat_last;
  logic [10:0]           mps_w, dwa_lo, room, split_chunk;
  logic [127:0]          align_beat;
  logic [31:0]           hdr_dw0, hdr_dw1, hdr_dw2;
  logic                  unused_addr;

  assign unused_addr = ^{i_mrd_addr[63:ADDR_WIDTH+4], i_mrd_addr[1:0]};

  assign is_beat   = (state_q == ST_HDR) || (state_q == ST_DATA);
  assign beat_hs   = is_beat && i_axis_slave_trdy;
  assign beat_last = (left_q <= 11'd4);

  // Largest chunk that stays inside the current MPS-aligned window
  always_comb begin
    mps_w       = mps_dw(i_cfg_max_payload_size);
    dwa_lo      = 11'(dwa_q);
    room        = mps_w - (dwa_lo & (mps_w - 11'd1));
    split_chunk = (rem_q < room) ? rem_q : room;
  end

  // Next-state and request/TLP bookkeeping
  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    attr_d  = attr_q;
    rid_d   = rid_q;
    tag_d   = tag_q;
    rem_d   = rem_q;
    dwa_d   = dwa_q;
    chunk_d = chunk_q;
    bcnt_d  = bcnt_q;
    laddr_d = laddr_q;
    left_d  = left_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE: begin
        if (i_cpld_req_vld) begin
          tc_d    = i_mrd_tc;
          attr_d  = i_mrd_attr;
          rid_d   = i_mrd_id;
          tag_d   = i_mrd_tag;
          rem_d   = (i_mrd_length == 10'd0) ? 11'd1024 : {1'b0, i_mrd_length};
          dwa_d   = i_mrd_addr[ADDR_WIDTH+3:2];
          state_d = ST_SPLIT;
        end
      end
      ST_SPLIT: begin
        chunk_d = split_chunk;
        bcnt_d  = {rem_q[9:0], 2'b00};
        laddr_d = {dwa_q[4:0], 2'b00};
        left_d  = split_chunk + 11'd3;
        word_d  = dwa_q[DWA_W-1:2];
        state_d = ST_PREF;
      end
      ST_PREF: begin
        word_d  = word_q + ADDR_WIDTH'(1);
        state_d = ST_HDR;
      end
      ST_HDR, ST_DATA: begin
        if (i_axis_slave_trdy) begin
          if (beat_last) begin
            rem_d   = rem_q - chunk_q;
            dwa_d   = dwa_q + DWA_W'(chunk_q);
            state_d = (rem_q == chunk_q) ? ST_IDLE : ST_SPLIT;
          end else begin
            left_d  = left_q - 11'd4;
            word_d  = word_q + ADDR_WIDTH'(1);
            state_d = ST_DATA;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tc_q    <= '0;
      attr_q  <= '0;
      rid_q   <= '0;
      tag_q   <= '0;
      rem_q   <= '0;
      dwa_q   <= '0;
      chunk_q <= '0;
      bcnt_q  <= '0;
      laddr_q <= '0;
      left_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      attr_q  <= attr_d;
      rid_q   <= rid_d;
      tag_q   <= tag_d;
      rem_q   <= rem_d;
      dwa_q   <= dwa_d;
      chunk_q <= chunk_d;
      bcnt_q  <= bcnt_d;
      laddr_q <= laddr_d;
      left_q  <= left_d;
      word_q  <= word_d;
    end
  end

  ips2l_pcie_dma_tx_dw_align u_align (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_word   (i_bar0_rd_data),
    .i_offset (dwa_q[1:0]),
    .i_hold   (!beat_hs),
    .o_beat   (align_beat)
  );

  assign hdr_dw0 = cpld_dw0(tc_q, attr_q, chunk_q[9:0]);
  assign hdr_dw1 = {i_cfg_completer_id, 3'b000, 1'b0, bcnt_q};
  assign hdr_dw2 = {rid_q, tag_q, 1'b0, laddr_q};

  // A RAM read is issued in PREF and on every non-final beat transfer, so
  // stalls freeze the address, the RAM output and the holding register.
  assign o_bar0_rd_clk_en = (state_q == ST_PREF) || (beat_hs && !beat_last);
  assign o_bar0_rd_addr   = word_q;
  assign o_cpld_req_rdy   = (state_q == ST_IDLE);
  assign o_cpld_tx_rdy    = (state_q == ST_IDLE);
  assign o_dbg_state      = state_q;

  // AXIS beat formation, forced to zero outside a TLP
  always_comb begin
    o_axis_slave_tvld  = is_beat;
    o_axis_slave_tdata = '0;
    o_axis_slave_tkeep = '0;
    o_axis_slave_tlast = 1'b0;
    if (is_beat) begin
      o_axis_slave_tdata = (state_q == ST_HDR) ?
                           {align_beat[127:96], hdr_dw2, hdr_dw1, hdr_dw0} : align_beat;
      o_axis_slave_tkeep = beat_last ? keep_mask(left_q) : 4'b1111;
      o_axis_slave_tlast = beat_last;
    end
  end

`ifdef CPLD_STAT_EN
  logic [31:0] cpld_cnt_q, cpld_cnt_d, dw_cnt_q, dw_cnt_d;

  // Count completed TLPs and their payload DWs
  always_comb begin
    cpld_cnt_d = cpld_cnt_q;
    dw_cnt_d   = dw_cnt_q;
    if (beat_hs && beat_last) begin
      cpld_cnt_d = cpld_cnt_q + 32'd1;
      dw_cnt_d   = dw_cnt_q + 32'(chunk_q);
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpld_cnt_q <= '0;
      dw_cnt_q   <= '0;
    end else begin
      cpld_cnt_q <= cpld_cnt_d;
      dw_cnt_q   <= dw_cnt_d;
    end
  end

  assign o_cpld_stat = {cpld_cnt_q, dw_cnt_q};
`else
  assign o_cpld_stat = '0;
`endif

endmodule

// File: tb/tb_ips2l_pcie_dma_tx_cpld_gen.sv
// Bench for ips2l_pcie_dma_tx_cpld_gen: request driver, BAR0 RAM model,
// TLP-level reference model feeding an expected-beat queue, and a monitor
// that checks every transferred beat plus AXIS stall behaviour.
// Honours CPLD_STAT_EN the same way as the design.
module tb_ips2l_pcie_dma_tx_cpld_gen;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    cfg_mps;
  logic [15:0]   cfg_cid;
  logic [2:0]    mrd_tc, mrd_attr;
  logic [9:0]    mrd_len;
  logic [15:0]   mrd_id;
  logic [7:0]    mrd_tag;
  logic [63:0]   mrd_addr;
  logic          req_vld;
  logic          req_rdy, tx_rdy, rd_en;
  logic [AW-1:0] rd_addr;
  logic [127:0]  rd_data;
  logic          tvld, trdy, tlast;
  logic [127:0]  tdata;
  logic [3:0]    tkeep;
  logic [63:0]   stat;
  logic [2:0]    dbg_state;

  ips2l_pcie_dma_tx_cpld_gen #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cfg_max_payload_size(cfg_mps), .i_cfg_completer_id(cfg_cid),
    .i_mrd_tc(mrd_tc), .i_mrd_attr(mrd_attr), .i_mrd_length(mrd_len),
    .i_mrd_id(mrd_id), .i_mrd_tag(mrd_tag), .i_mrd_addr(mrd_addr),
    .i_cpld_req_vld(req_vld), .o_cpld_req_rdy(req_rdy), .o_cpld_tx_rdy(tx_rdy),
    .o_bar0_rd_clk_en(rd_en), .o_bar0_rd_addr(rd_addr), .i_bar0_rd_data(rd_data),
    .o_axis_slave_tvld(tvld), .i_axis_slave_trdy(trdy), .o_axis_slave_tdata(tdata),
    .o_axis_slave_tkeep(tkeep), .o_axis_slave_tlast(tlast), .o_cpld_stat(stat),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- BAR0 RAM model ----------------
  logic [127:0] ram [0:511];
  logic [127:0] ram_q = '0;
  always @(posedge clk) if (rd_en) ram_q <= ram[rd_addr];
  assign rd_data = ram_q;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q[$];
  logic [3:0]   exp_keep_q[$];
  logic         exp_last_q[$];
  longint       exp_cpld_cnt = 0;
  longint       exp_dw_cnt = 0;
  logic         stall_mode = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ram_dw(input int idx);
    logic [127:0] w;
    w = ram[(idx >> 2) & 511];
    return w[32*(idx & 3) +: 32];
  endfunction

  // Reference model: split the request into CplDs and the CplDs into beats
  task automatic model_push(input int len, input logic [63:0] addr, input logic [2:0] tc,
                            input logic [2:0] attr, input logic [15:0] rid,
                            input logic [7:0] tag, input int mps, input logic [15:0] cid);
    int rem, dwa, mdw, chunk, n;
    logic [31:0] dq[$];
    logic [127:0] d;
    logic [3:0] k;
    logic [9:0] l10;
    logic [11:0] bc;
    logic [6:0] la;
    rem = (len == 0) ? 1024 : len;
    dwa = int'(addr >> 2) & 2047;
    while (rem > 0) begin
      mdw   = 32 << ((mps > 5) ? 5 : mps);
      chunk = mdw - (dwa % mdw);
      if (rem < chunk) chunk = rem;
      l10 = 10'(chunk);
      bc  = 12'((rem * 4) % 4096);
      la  = 7'((dwa % 32) * 4);
      dq.delete();
      dq.push_back({3'b010, 5'b01010, 1'b0, tc, 1'b0, attr[2], 2'b00, 1'b0, 1'b0,
                    attr[1:0], 2'b00, l10});
      dq.push_back({cid, 3'b000, 1'b0, bc});
      dq.push_back({rid, tag, 1'b0, la});
      for (int i = 0; i < chunk; i++) dq.push_back(ram_dw(dwa + i));
      while (dq.size() > 0) begin
        n = (dq.size() < 4) ? dq.size() : 4;
        d = '0;
        k = '0;
        for (int j = 0; j < n; j++) begin
          d[32*j +: 32] = dq.pop_front();
          k[j] = 1'b1;
        end
        exp_q.push_back(d);
        exp_keep_q.push_back(k);
        exp_last_q.push_back(dq.size() == 0);
      end
      exp_cpld_cnt++;
      exp_dw_cnt += chunk;
      rem -= chunk;
      dwa = (dwa + chunk) % 2048;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_req(input int len, input logic [63:0] addr, output int waited);
    @(posedge clk);
    #1;
    mrd_len  = 10'(len);
    mrd_addr = addr;
    mrd_tc   = 3'($urandom_range(0, 7));
    mrd_attr = 3'($urandom_range(0, 7));
    mrd_id   = 16'($urandom);
    mrd_tag  = 8'($urandom);
    req_vld  = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (req_rdy) break;
      waited++;
      if (waited > 5000) begin
        check("req_accept_timeout", 1'b1, 1'b0);
        break;
      end
    end
    model_push(len, addr, mrd_tc, mrd_attr, mrd_id, mrd_tag, int'(cfg_mps), cfg_cid);
    @(posedge clk);
    #1 req_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && tx_rdy) break;
      cyc++;
      if (cyc > 20000) begin
        check("idle_timeout", 1'b1, 1'b0);
        break;
      end
    end
  endtask

  task automatic check_stat(input string name);
    logic [63:0] e;
`ifdef CPLD_STAT_EN
    e = {32'(exp_cpld_cnt), 32'(exp_dw_cnt)};
`else
    e = '0;
`endif
    check(name, stat, e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvld"},  tvld, 0);
    check({tag, "_tdata"}, tdata, 0);
    check({tag, "_tkeep"}, tkeep, 0);
    check({tag, "_tlast"}, tlast, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_stat"},  stat, 0);
    check({tag, "_req_rdy"}, req_rdy, 1);
    check({tag, "_tx_rdy"}, tx_rdy, 1);
  endtask

  // ---------------- AXIS ready driver ----------------
  initial begin
    trdy = 1'b0;
    forever begin
      @(posedge clk);
      #1 trdy = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic stalled;
    logic [127:0] sd, m, ed;
    logic [3:0] sk, ek;
    logic sl, el;
    stalled = 1'b0;
    sd = '0; sk = '0; sl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        check("stall_tvld", tvld, 1);
        check("stall_tdata", tdata, sd);
        check("stall_tkeep", tkeep, sk);
        check("stall_tlast", tlast, sl);
      end
      if (tvld) check("busy_req_rdy", req_rdy, 0);
      if (tvld && !trdy) check("stall_rd_en", rd_en, 0);
      if (tvld && trdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          ed = exp_q.pop_front();
          ek = exp_keep_q.pop_front();
          el = exp_last_q.pop_front();
          for (int i = 0; i < 4; i++) m[32*i +: 32] = {32{ek[i]}};
          check("beat_data", tdata & m, ed);
          check("beat_keep", tkeep, ek);
          check("beat_last", tlast, el);
        end
      end
      stalled = tvld && !trdy;
      sd = tdata; sk = tkeep; sl = tlast;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int w, len;
    logic [63:0] a;
    rst_n = 1'b0;
    req_vld = 1'b0;
    cfg_mps = 3'd0;
    cfg_cid = 16'h1234;
    mrd_tc = '0; mrd_attr = '0; mrd_len = '0; mrd_id = '0; mrd_tag = '0; mrd_addr = '0;
    for (int i = 0; i < 512; i++) ram[i] = {$urandom, $urandom, $urandom, $urandom};
    ram[1] = 128'hDDCCBBAA_99887766_55443322_44332211;
    repeat (3) @(posedge clk);
    #2 check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single-DW completion
    send_req(1, 64'h10, w);
    wait_idle();
    // 64 DW at 128B MPS: split into 16/32/16
    send_req(64, 64'h40, w);
    wait_idle();
    check_stat("stat_after_t1_t3");

    // 8 DW unaligned, no stalls then with random stalls
    send_req(8, 64'h04, w);
    wait_idle();
    stall_mode = 1'b1;
    send_req(8, 64'h04, w);
    wait_idle();

    // last RAM word with wrap, second request queued behind it
    cfg_mps = 3'd2;
    send_req(8, 64'h1FF8, w);
    send_req(5, 64'h1FFC, w);
    check("second_req_waited", w > 0, 1);
    wait_idle();

    // randomized requests
    for (int t = 0; t < 24; t++) begin
      stall_mode = 1'($urandom_range(0, 1));
      cfg_mps = 3'($urandom_range(0, 7));
      cfg_cid = 16'($urandom);
      len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 300);
      a = {$urandom, $urandom};
      send_req(len, a, w);
      wait_idle();
    end
    check_stat("stat_after_random");

    // reset in the middle of a long TLP
    stall_mode = 1'b1;
    cfg_mps = 3'd5;
    send_req(0, 64'h0, w);
    repeat (40) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    exp_q.delete();
    exp_keep_q.delete();
    exp_last_q.delete();
    exp_cpld_cnt = 0;
    exp_dw_cnt = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // recovery after reset
    stall_mode = 1'b0;
    cfg_mps = 3'd1;
    send_req(70, 64'h123, w);
    wait_idle();
    check_stat("stat_after_recovery");
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
